tie_seq_ctrl: RTL and testbench
===============================

# tie_seq_ctrl

Power-sequencing controller for the board's static control lines: enables, tie-offs and strap levels that would otherwise be driven as fixed constants. It holds every line at a safe OFF level from reset. On request it drives the lines to their ON levels one at a time, in index order, with a fixed step delay. On shutdown it returns them to OFF in reverse order. It sits at the top level between the host command decoder (start/stop requests) and the pads of the controlled lines.

## Interface
- N_LINES, 4, number of sequenced lines (1..16)
- OFF_LEVEL, {N_LINES{1'b0}}, per-bit safe level held in reset and in OFF
- ON_LEVEL, {N_LINES{1'b1}}, per-bit operating level
- STEP_CYCLES, 1000, clk cycles between consecutive line transitions (>=1)
- clk  input  1  system clock; single clock domain
- rst  input  1  asynchronous, active-high reset
- start_req  input  1  level request to power up; sampled each clk edge
- stop_req  input  1  level request to power down; takes priority over start_req
- lines  output  N_LINES  sequenced control levels, registered
- ready  output  1  high only in ON (all lines at ON_LEVEL)
- busy  output  1  high in UP or DOWN
- idx  output  clog2(N_LINES+1)  number of lines currently at ON level (0..N_LINES)

## Operation
- States: OFF, UP, ON, DOWN. Reset forces OFF, lines=OFF_LEVEL, idx=0, ready=0, busy=0, step counter=0, asynchronously.
- OFF: start_req=1 and stop_req=0 -> UP, counter loaded STEP_CYCLES-1.
- UP: counter decrements each cycle. At an edge with counter==0: lines[idx] <= ON_LEVEL[idx], idx++, counter reloaded. When idx reaches N_LINES -> ON.
- ON: lines==ON_LEVEL, ready=1. stop_req=1 -> DOWN, counter loaded STEP_CYCLES-1.
- DOWN: at an edge with counter==0: lines[idx-1] <= OFF_LEVEL[idx-1], idx--, counter reloaded. When idx reaches 0 -> OFF.
- stop_req during UP -> DOWN immediately. Counter reloads; the reverse sequence starts from the highest line already ON. With idx==0, DOWN completes to OFF after one step with no line change.
- start_req (stop_req=0) during DOWN -> UP immediately. Counter reloads; the sequence resumes from the current idx.
- start_req and stop_req both high: treated as stop in every state.
- Bits whose ON_LEVEL equals OFF_LEVEL still consume a step; no glitch on the output.
- Only one line changes per transition edge. Never two lines in the same cycle.

## Timing
- start_req sampled high at edge t0 (state OFF): state=UP after t0. Line k reaches ON at edge t0+(k+1)*STEP_CYCLES.
- ready rises at the same edge the last line switches. busy falls at that same edge.
- DOWN timing is symmetric: line k returns to OFF at edge t0+(N_LINES-k)*STEP_CYCLES, where t0 is the edge at which stop_req is sampled in ON.
- STEP_CYCLES=1: one line per cycle. Full UP takes N_LINES cycles.
- Requests are levels, not pulses. A request that drops before being sampled is ignored.

## Structure
- Shared package/header: state encodings (OFF=2'd0, UP=2'd1, ON=2'd2, DOWN=2'd3) and the clog2 function.
- Natural sub-module: step_timer (loadable down-counter with a zero flag, width clog2(STEP_CYCLES)). The FSM and the line register stay in tie_seq_ctrl.

## Test plan
Unless noted: N_LINES=4, STEP_CYCLES=3, OFF_LEVEL=4'b0000, ON_LEVEL=4'b1011.
- Reset then start_req at edge t0 -> lines 0001@t0+3, 0011@t0+6, 0011@t0+9 (bit2 stays 0, idx=3), 1011@t0+12; ready=1 and busy=0 at t0+12.
- From ON, stop_req at t1 -> lines 0011@t1+3, 0011@t1+6, 0001@t1+9, 0000@t1+12; state OFF, idx=0.
- stop_req at t0+7 during UP (lines=0011) -> 0001@t0+10, 0000@t0+13; ready never asserted.
- start_req and stop_req both high in OFF for 20 cycles -> lines stay 0000, busy=0.
- rst pulsed mid-UP, asynchronous to clk -> lines=0000, ready=0, busy=0, idx=0 before the next clk edge.
- STEP_CYCLES=1 build, start at t0 -> one line per edge, ready at t0+4; no cycle with two bits changing.

Source files
------------

// File: rtl/tie_seq_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// tie_seq_ctrl_pkg
// Shared definitions for the power-sequencing controller.
//   - FSM state encodings (OFF, UP, ON, DOWN)
//   - clog2 helper used to size the index and step-counter registers
// -----------------------------------------------------------------------------
package tie_seq_ctrl_pkg;

  localparam logic [1:0] ST_OFF  = 2'd0;
  localparam logic [1:0] ST_UP   = 2'd1;
  localparam logic [1:0] ST_ON   = 2'd2;
  localparam logic [1:0] ST_DOWN = 2'd3;

  // Ceiling log2. clog2(1) is 0, so callers that need a real register must
  // clamp the result to at least one bit.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >>> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/tie_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// tie_seq_ctrl_if
// Bundle between the host command decoder and the sequencing controller.
//   start_req  host -> ctrl  level request to power up
//   stop_req   host -> ctrl  level request to power down (wins over start_req)
//   lines      ctrl -> pads  sequenced control levels
//   ready      ctrl -> host  all lines at their ON level
//   busy       ctrl -> host  sequence in progress (UP or DOWN)
//   idx        ctrl -> host  number of lines currently at their ON level
// Modports: master = host side, slave = controller side.
// -----------------------------------------------------------------------------
interface tie_seq_ctrl_if #(
  parameter int N_LINES = 4
);

  localparam int IDX_W = tie_seq_ctrl_pkg::clog2(N_LINES + 1);

  logic               start_req;
  logic               stop_req;
  logic [N_LINES-1:0] lines;
  logic               ready;
  logic               busy;
  logic [IDX_W-1:0]   idx;

  modport master (
    output start_req,
    output stop_req,
    input  lines,
    input  ready,
    input  busy,
    input  idx
  );

  modport slave (
    input  start_req,
    input  stop_req,
    output lines,
    output ready,
    output busy,
    output idx
  );

endinterface

// File: rtl/tie_seq_ctrl_step_timer.sv
// -----------------------------------------------------------------------------
// tie_seq_ctrl_step_timer
// Loadable down-counter that paces line transitions.
//   clk   system clock
//   rst   asynchronous active-high reset (counter cleared to 0)
//   load  reload the counter with STEP_CYCLES-1 on this edge
//   zero  counter is at 0; the controller fires a step on this edge
// Without load the counter decrements and saturates at 0.
// -----------------------------------------------------------------------------
module tie_seq_ctrl_step_timer
  import tie_seq_ctrl_pkg::*;
#(
  parameter int STEP_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic zero
);

  // STEP_CYCLES=1 would give a zero-width counter; keep one bit that simply
  // reloads to 0 every step.
  localparam int CNT_W = (clog2(STEP_CYCLES) < 1) ? 1 : clog2(STEP_CYCLES);
  localparam logic [CNT_W-1:0] RELOAD  = CNT_W'(STEP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = RELOAD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_ONE;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its peers regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/tie_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tie_seq_ctrl
// Power-sequencing controller for static board control lines. Holds every line
// at OFF_LEVEL from reset, steps lines to ON_LEVEL one at a time in index order
// on a start request, and back to OFF_LEVEL in reverse order on a stop request.
//   clk   system clock
//   rst   asynchronous active-high reset
//   bus   tie_seq_ctrl_if.slave: start_req/stop_req in; lines/ready/busy/idx out
// Parameters: N_LINES (1..16), OFF_LEVEL, ON_LEVEL, STEP_CYCLES (>=1).
// -----------------------------------------------------------------------------
module tie_seq_ctrl
  import tie_seq_ctrl_pkg::*;
#(
  parameter int                 N_LINES     = 4,
  parameter logic [N_LINES-1:0] OFF_LEVEL   = '0,
  parameter logic [N_LINES-1:0] ON_LEVEL    = '1,
  parameter int                 STEP_CYCLES = 1000
) (
  input  logic            clk,
  input  logic            rst,
  tie_seq_ctrl_if.slave   bus
);

  localparam int IDX_W = clog2(N_LINES + 1);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

  logic [1:0]         state_q, state_d;
  logic [N_LINES-1:0] lines_q, lines_d;
  logic [IDX_W-1:0]   idx_q,   idx_d;
  logic               step_load;
  logic               step_zero;

  // A simultaneous start and stop is a stop.
  logic go_up;
  logic go_down;
  assign go_up   = bus.start_req && !bus.stop_req;
  assign go_down = bus.stop_req;

  tie_seq_ctrl_step_timer #(
    .STEP_CYCLES (STEP_CYCLES)
  ) u_step_timer (
    .clk  (clk),
    .rst  (rst),
    .load (step_load),
    .zero (step_zero)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d   = state_q;
    lines_d   = lines_q;
    idx_d     = idx_q;
    step_load = 1'b0;

    case (state_q)
      ST_OFF: begin
        if (go_up) begin
          state_d   = ST_UP;
          step_load = 1'b1;
        end
      end

      ST_UP: begin
        if (go_down) begin
          state_d   = ST_DOWN;
          step_load = 1'b1;
        end else if (step_zero) begin
          // Only the line at idx is touched, so at most one bit can move.
          for (int i = 0; i < N_LINES; i++) begin
            if (int'(idx_q) == i) lines_d[i] = ON_LEVEL[i];
          end
          idx_d     = idx_q + IDX_ONE;
          step_load = 1'b1;
          if (int'(idx_q) == N_LINES - 1) state_d = ST_ON;
        end
      end

      ST_ON: begin
        if (go_down) begin
          state_d   = ST_DOWN;
          step_load = 1'b1;
        end
      end

      ST_DOWN: begin
        if (go_up) begin
          state_d   = ST_UP;
          step_load = 1'b1;
        end else if (step_zero) begin
          // idx==0 (aborted before any line came up) still spends one step,
          // then lands in OFF with no line change.
          if (idx_q != '0) begin
            for (int i = 0; i < N_LINES; i++) begin
              if (int'(idx_q) == i + 1) lines_d[i] = OFF_LEVEL[i];
            end
            idx_d = idx_q - IDX_ONE;
          end
          step_load = 1'b1;
          if (idx_q <= IDX_ONE) state_d = ST_OFF;
        end
      end

      default: begin
        state_d = ST_OFF;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_OFF;
      lines_q <= OFF_LEVEL;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      lines_q <= lines_d;
      idx_q   <= idx_d;
    end
  end

  // Decoded from the state register, so ready rises and busy falls on the
  // same edge that switches the last line.
  assign bus.lines = lines_q;
  assign bus.idx   = idx_q;
  assign bus.ready = (state_q == ST_ON);
  assign bus.busy  = (state_q == ST_UP) || (state_q == ST_DOWN);

endmodule

// File: tb/tb_tie_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tie_seq_ctrl
// Directed bench for tie_seq_ctrl. Two instances share clk/rst:
//   dut3: N_LINES=4, STEP_CYCLES=3, ON_LEVEL=4'b1011
//   dut1: N_LINES=4, STEP_CYCLES=1, ON_LEVEL=4'b1111
// Inputs are driven and outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_tie_seq_ctrl;

  logic clk;
  logic rst;

  int n_cmp;
  int n_err;

  int ready_seen3;
  int multi3;
  int multi1;
  logic [3:0] prev3;
  logic [3:0] prev1;

  tie_seq_ctrl_if #(.N_LINES(4)) bus3 ();
  tie_seq_ctrl_if #(.N_LINES(4)) bus1 ();

  tie_seq_ctrl #(
    .N_LINES     (4),
    .OFF_LEVEL   (4'b0000),
    .ON_LEVEL    (4'b1011),
    .STEP_CYCLES (3)
  ) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3)
  );

  tie_seq_ctrl #(
    .N_LINES     (4),
    .OFF_LEVEL   (4'b0000),
    .ON_LEVEL    (4'b1111),
    .STEP_CYCLES (1)
  ) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sticky observers: ready ever high on dut3, and any sample where more than
  // one line moved at once.
  always @(negedge clk) begin
    if (bus3.ready === 1'b1) ready_seen3 = ready_seen3 + 1;
    if ($countones(bus3.lines ^ prev3) > 1) multi3 = multi3 + 1;
    if ($countones(bus1.lines ^ prev1) > 1) multi1 = multi1 + 1;
    prev3 = bus3.lines;
    prev1 = bus1.lines;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges and stop on the following falling edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check3(input string tag, input logic [3:0] l, input int i,
                        input logic r, input logic b);
    check({tag, ".lines"}, 32'(bus3.lines), 32'(l));
    check({tag, ".idx"},   32'(bus3.idx),   32'(i));
    check({tag, ".ready"}, 32'(bus3.ready), 32'(r));
    check({tag, ".busy"},  32'(bus3.busy),  32'(b));
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    ready_seen3 = 0;
    multi3 = 0;
    multi1 = 0;
    prev3 = 4'b0000;
    prev1 = 4'b0000;
    bus3.start_req = 1'b0;
    bus3.stop_req  = 1'b0;
    bus1.start_req = 1'b0;
    bus1.stop_req  = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    step(1);

    // Reset state
    check3("reset", 4'b0000, 0, 1'b0, 1'b0);

    // Power-up with STEP_CYCLES=3; start sampled at edge t0
    bus3.start_req = 1'b1;
    step(1);
    bus3.start_req = 1'b0;
    check3("up_t0", 4'b0000, 0, 1'b0, 1'b1);
    step(2);
    check("up_t0+2.lines", 32'(bus3.lines), 32'h0);
    step(1);
    check3("up_t0+3", 4'b0001, 1, 1'b0, 1'b1);
    step(3);
    check3("up_t0+6", 4'b0011, 2, 1'b0, 1'b1);
    step(3);
    check3("up_t0+9", 4'b0011, 3, 1'b0, 1'b1);
    step(2);
    check3("up_t0+11", 4'b0011, 3, 1'b0, 1'b1);
    step(1);
    check3("up_t0+12", 4'b1011, 4, 1'b1, 1'b0);
    step(5);
    check3("on_hold", 4'b1011, 4, 1'b1, 1'b0);

    // Power-down from ON; stop sampled at edge t1
    bus3.stop_req = 1'b1;
    step(1);
    bus3.stop_req = 1'b0;
    check3("dn_t1", 4'b1011, 4, 1'b0, 1'b1);
    step(3);
    check3("dn_t1+3", 4'b0011, 3, 1'b0, 1'b1);
    step(3);
    check3("dn_t1+6", 4'b0011, 2, 1'b0, 1'b1);
    step(3);
    check3("dn_t1+9", 4'b0001, 1, 1'b0, 1'b1);
    step(3);
    check3("dn_t1+12", 4'b0000, 0, 1'b0, 1'b0);
    step(4);
    check3("off_hold", 4'b0000, 0, 1'b0, 1'b0);

    // Stop at t0+7 during UP: reverse from the highest line already on
    ready_seen3 = 0;
    bus3.start_req = 1'b1;
    step(1);
    bus3.start_req = 1'b0;
    step(6);
    bus3.stop_req = 1'b1;
    step(1);
    bus3.stop_req = 1'b0;
    check3("abort_t0+7", 4'b0011, 2, 1'b0, 1'b1);
    step(3);
    check3("abort_t0+10", 4'b0001, 1, 1'b0, 1'b1);
    step(3);
    check3("abort_t0+13", 4'b0000, 0, 1'b0, 1'b0);
    check("abort.ready_never", 32'(ready_seen3), 32'd0);

    // Start during DOWN resumes from current idx
    bus3.start_req = 1'b1;
    step(1);
    bus3.start_req = 1'b0;
    step(12);
    check3("resume_on", 4'b1011, 4, 1'b1, 1'b0);
    bus3.stop_req = 1'b1;
    step(1);
    bus3.stop_req = 1'b0;
    step(3);
    check3("resume_dn3", 4'b0011, 3, 1'b0, 1'b1);
    bus3.start_req = 1'b1;
    step(1);
    bus3.start_req = 1'b0;
    check3("resume_up0", 4'b0011, 3, 1'b0, 1'b1);
    step(2);
    check("resume_up2.lines", 32'(bus3.lines), 32'hb & 32'h3);
    step(1);
    check3("resume_up3", 4'b1011, 4, 1'b1, 1'b0);
    bus3.stop_req = 1'b1;
    step(1);
    bus3.stop_req = 1'b0;
    step(12);
    check3("resume_off", 4'b0000, 0, 1'b0, 1'b0);

    // Start and stop both high in OFF: stop wins
    bus3.start_req = 1'b1;
    bus3.stop_req  = 1'b1;
    step(20);
    check3("both_off", 4'b0000, 0, 1'b0, 1'b0);
    bus3.start_req = 1'b0;
    bus3.stop_req  = 1'b0;

    // Asynchronous reset mid-UP
    bus3.start_req = 1'b1;
    step(1);
    bus3.start_req = 1'b0;
    step(5);
    check3("pre_rst", 4'b0001, 1, 1'b0, 1'b1);
    #2 rst = 1'b1;
    #1;
    check3("async_rst", 4'b0000, 0, 1'b0, 1'b0);
    rst = 1'b0;
    step(1);
    // Sequence restarts cleanly with a fresh step count
    bus3.start_req = 1'b1;
    step(1);
    bus3.start_req = 1'b0;
    step(2);
    check("post_rst_t0+2.lines", 32'(bus3.lines), 32'h0);
    step(1);
    check3("post_rst_t0+3", 4'b0001, 1, 1'b0, 1'b1);
    bus3.stop_req = 1'b1;
    step(1);
    bus3.stop_req = 1'b0;
    step(6);
    check3("post_rst_off", 4'b0000, 0, 1'b0, 1'b0);

    // STEP_CYCLES=1: one line per edge
    bus1.start_req = 1'b1;
    step(1);
    bus1.start_req = 1'b0;
    check("s1_t0.lines", 32'(bus1.lines), 32'h0);
    check("s1_t0.busy",  32'(bus1.busy),  32'h1);
    step(1);
    check("s1_t0+1.lines", 32'(bus1.lines), 32'h1);
    step(1);
    check("s1_t0+2.lines", 32'(bus1.lines), 32'h3);
    step(1);
    check("s1_t0+3.lines", 32'(bus1.lines), 32'h7);
    check("s1_t0+3.ready", 32'(bus1.ready), 32'h0);
    step(1);
    check("s1_t0+4.lines", 32'(bus1.lines), 32'hf);
    check("s1_t0+4.ready", 32'(bus1.ready), 32'h1);
    check("s1_t0+4.busy",  32'(bus1.busy),  32'h0);
    check("s1_t0+4.idx",   32'(bus1.idx),   32'd4);
    bus1.stop_req = 1'b1;
    step(1);
    bus1.stop_req = 1'b0;
    step(1);
    check("s1_dn1.lines", 32'(bus1.lines), 32'h7);
    step(3);
    check("s1_dn4.lines", 32'(bus1.lines), 32'h0);
    check("s1_dn4.busy",  32'(bus1.busy),  32'h0);

    check("one_bit_per_edge.dut3", 32'(multi3), 32'd0);
    check("one_bit_per_edge.dut1", 32'(multi1), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
